pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central hazard and stage-control block for the pipelined CPU, generalised in depth (NUM_STAGES, MEM_STAGE, REDIRECT_STAGE).
- Tracks a valid bit per pipeline stage.
- Produces per-stage enable and flush, the PC enable and ALU forwarding selects.
- Detects load-use hazards, resolves branch/jump redirect flushes, and stalls on a multi-cycle data-memory handshake with a timeout.
- Sits beside the datapath in cpu; drives every stage register and the pc enable.

Parameters:
NUM_STAGES, 5, total stages; 0=IF, 1=ID, 2=EX, last=WB; legal 5..8
MEM_STAGE, 3, data-memory stage index; 3 <= MEM_STAGE < NUM_STAGES-1
REDIRECT_STAGE, 3, stage in which branch/jump resolves; 2..MEM_STAGE
REG_ADDR_W, 5, register address width
MAX_WAIT, 16, memory-wait cycles before timeout; >= 1
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  run; low freezes whole pipeline
id_rs, id_rt  in  REG_ADDR_W  source registers in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rs, ex_rt  in  REG_ADDR_W  source registers in EX
ex_rd  in  REG_ADDR_W  destination register in EX
ex_mem_read  in  1  EX instruction is a load
mem_rd, wb_rd  in  REG_ADDR_W  destinations in MEM_STAGE / last stage
mem_reg_write, wb_reg_write  in  1  write enables of those stages
redirect  in  1  taken branch/jump in REDIRECT_STAGE
mem_req  in  1  MEM_STAGE instruction accesses data memory
mem_ack  in  1  data memory completes access this cycle
pc_en  out  1  pc update enable
stage_en  out  NUM_STAGES  per-stage register load enable
stage_flush  out  NUM_STAGES  per-stage kill (insert bubble)
stage_valid  out  NUM_STAGES  registered valid per stage
fwd_a, fwd_b  out  2  operand source: 00 regfile, 01 MEM_STAGE, 10 last stage
mem_timeout  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating stall-cycle count
flush_count  out  CNT_W  saturating redirect count

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT. Reset → RUN, stage_valid=0, wait counter 0, mem_timeout=0, counters 0.
- Combinational outputs take their value from the post-reset state: pc_en=enable, stage_en=all enable, stage_flush=0, fwd=00.
- Valid update on stage_en[i]: valid[i] <= valid[i-1] & ~stage_flush[i-1]. valid[0] <= 1 when pc_en. Stages with stage_en=0 hold their valid bit.
- Event priority is TIMEOUT > enable low > MEM_WAIT > redirect > load-use > normal.
- enable=0: all stage_en=0 and pc_en=0; counters hold; FSM holds.
- Memory wait:
  - Condition is RUN with valid[MEM_STAGE] & mem_req & ~mem_ack. Enter MEM_WAIT the same cycle.
  - Stages 0..MEM_STAGE are frozen and pc_en=0. Stages after MEM_STAGE advance; MEM_STAGE+1 receives a bubble.
  - mem_ack while in MEM_WAIT → advance that cycle, return to RUN.
  - The counter counts each frozen cycle. Reaching MAX_WAIT without ack → TIMEOUT.
- TIMEOUT: all enables 0, mem_timeout=1; left only by rst.
- Redirect:
  - Condition is valid[REDIRECT_STAGE] & redirect in RUN.
  - stage_flush[0..REDIRECT_STAGE-1]=1 and flush_count += 1. Any concurrent load-use stall is cancelled.
  - pc_en=1, so pc loads the target.
- Load-use hazard:
  - Condition: valid[2] & valid[1] & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Response: stage_en[0..1]=0, pc_en=0, stage_flush[1]=1 (bubble into EX), later stages advance. Exactly one cycle per hazard.
- Forwarding (combinational):
  - fwd_a=01 if valid[MEM_STAGE] & mem_reg_write & mem_rd!=0 & mem_rd==ex_rs.
  - Else 10 if the last stage matches wb_rd under the same rule.
  - Else 00.
  - fwd_b is identical using ex_rt. The MEM_STAGE source takes priority over the last stage.
- stall_cycles increments on every cycle where any stage_en[0]=0 while enable=1 (load-use, MEM_WAIT, TIMEOUT). Both counters saturate at all-ones.
- rst mid-MEM_WAIT or in TIMEOUT returns to the reset values at the next edge.

Decomposition:
- Package pipeline_pkg holds:
  - stage index constants IF_STG=0, ID_STG=1, EX_STG=2;
  - FSM state enum;
  - fwd select encodings FWD_RF, FWD_MEM, FWD_WB.
- Sub-module: hazard_fwd_unit, purely combinational load-use detect plus forwarding selects. The FSM, valid chain and counters stay in the top level.

Test Plan:
- Load-use: EX lw r2 (ex_mem_read=1, ex_rd=2), ID add with id_rs=2 → one cycle with pc_en=0, stage_en[1:0]=00, stage_flush[1]=1; stall_cycles=1; ex_rd=0 gives no stall.
- Forwarding: ex_rs=3 with mem_rd=3, mem_reg_write=1, valid → fwd_a=01. Add wb_rd=3 as well → still 01. Clear MEM match → 10. mem_rd=0 → 00.
- Redirect plus simultaneous load-use at REDIRECT_STAGE=3 → stage_flush=00111, no stall. Next cycle stage_valid[2:0]=000 except the new fetch. flush_count=1.
- mem_req held, mem_ack after 3 cycles → stages 0..3 frozen 3 cycles, WB gets bubbles, stall_cycles=3, back to RUN. With MAX_WAIT=4 and no ack → mem_timeout=1 sticky until rst.
- enable=0 for 5 cycles mid-stream → stage_valid and counters unchanged. rst during MEM_WAIT → RUN, all outputs at reset values.
- NUM_STAGES=7, MEM_STAGE=4, REDIRECT_STAGE=4 → redirect flushes stages 0..3; WB forwarding comes from stage 6.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_pkg: shared constants and types for the pipeline control block.
//   - fixed stage indices for the front of the pipe (IF/ID/EX)
//   - control FSM state encoding
//   - operand forwarding select encodings
package pipeline_pkg;

  localparam int IF_STG = 0;
  localparam int ID_STG = 1;
  localparam int EX_STG = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: datapath <-> pipeline control bundle.
//   master (datapath): drives register fields, hazard qualifiers, redirect and
//                      the data-memory handshake; receives forwarding selects.
//   slave  (control) : the mirror image.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic                  id_uses_rt, ex_mem_read;
  logic                  mem_reg_write, wb_reg_write;
  logic                  redirect;
  logic                  mem_req, mem_ack;
  logic [1:0]            fwd_a, fwd_b;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write, redirect, mem_req, mem_ack,
    input  fwd_a, fwd_b
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write, redirect, mem_req, mem_ack,
    output fwd_a, fwd_b
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit: purely combinational load-use detection and EX operand
// forwarding selects.
//   in : stage valids (ID, EX, MEM stage, last stage), register fields
//   out: load_use (stall request), fwd_a / fwd_b (FWD_RF / FWD_MEM / FWD_WB)
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  ex_valid,
  input  logic                  mem_valid,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  load_use,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  // r0 is hardwired zero, so it is never a forwarding or hazard source
  logic mem_src_ok, wb_src_ok;
  assign mem_src_ok = mem_valid & mem_reg_write & (mem_rd != '0);
  assign wb_src_ok  = wb_valid  & wb_reg_write  & (wb_rd  != '0);

  // Youngest producer (MEM stage) wins over the last stage
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  m_ok,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  w_ok,
    input logic [REG_ADDR_W-1:0] w_rd
  );
    if (m_ok && (m_rd == src))      return FWD_MEM;
    else if (w_ok && (w_rd == src)) return FWD_WB;
    else                            return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(ex_rs, mem_src_ok, mem_rd, wb_src_ok, wb_rd);
  assign fwd_b = fwd_sel(ex_rt, mem_src_ok, mem_rd, wb_src_ok, wb_rd);

  assign load_use = ex_valid & id_valid & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stage control for an NUM_STAGES-deep pipeline.
//   clk, rst (sync, active high), enable (low freezes everything)
//   bus          : pipeline_ctrl_if.slave (register fields, redirect, mem handshake, fwd selects)
//   pc_en        : pc update enable
//   stage_en     : per-stage register load enable
//   stage_flush  : stage_flush[i] turns what leaves stage i into a bubble
//   stage_valid  : registered valid per stage
//   mem_timeout  : sticky, cleared only by rst
//   stall_cycles / flush_count : saturating performance counters
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int MEM_STAGE      = 3,
  parameter int REDIRECT_STAGE = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int MAX_WAIT       = 16,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  pipeline_ctrl_if.slave        bus,
  output logic                  pc_en,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int LAST   = NUM_STAGES - 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              load_use, mem_hold, redir_go;

  hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hfu (
    .id_valid      (stage_valid[ID_STG]),
    .ex_valid      (stage_valid[EX_STG]),
    .mem_valid     (stage_valid[MEM_STAGE]),
    .wb_valid      (stage_valid[LAST]),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_uses_rt    (bus.id_uses_rt),
    .ex_rs         (bus.ex_rs),
    .ex_rt         (bus.ex_rt),
    .ex_rd         (bus.ex_rd),
    .ex_mem_read   (bus.ex_mem_read),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .load_use      (load_use),
    .fwd_a         (bus.fwd_a),
    .fwd_b         (bus.fwd_b)
  );

  // wait_cnt is 0 in RUN, so the entry cycle is counted as the first frozen one
  assign wait_nxt = wait_cnt + 1'b1;

  always_comb begin
    pc_en       = 1'b0;
    stage_en    = '0;
    stage_flush = '0;
    mem_hold    = 1'b0;
    redir_go    = 1'b0;
    if (state == TIMEOUT || !enable) begin
      // everything frozen
    end else if (!bus.mem_ack &&
                 (state == MEM_WAIT || (stage_valid[MEM_STAGE] && bus.mem_req))) begin
      // Front half waits on memory; back half drains with a bubble behind it
      mem_hold = 1'b1;
      for (int i = MEM_STAGE + 1; i < NUM_STAGES; i++) stage_en[i] = 1'b1;
      stage_flush[MEM_STAGE] = 1'b1;
    end else if (stage_valid[REDIRECT_STAGE] && bus.redirect) begin
      // Kill everything younger than the branch; overrides any load-use stall
      redir_go = 1'b1;
      pc_en    = 1'b1;
      stage_en = '1;
      for (int i = 0; i < REDIRECT_STAGE; i++) stage_flush[i] = 1'b1;
    end else if (load_use) begin
      stage_en                   = '1;
      stage_en[ID_STG:IF_STG]    = 2'b00;
      stage_flush[ID_STG]        = 1'b1;
    end else begin
      pc_en    = 1'b1;
      stage_en = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
      stage_valid  <= '0;
    end else begin
      if (stage_en[IF_STG]) stage_valid[IF_STG] <= pc_en;
      for (int i = 1; i < NUM_STAGES; i++)
        if (stage_en[i]) stage_valid[i] <= stage_valid[i-1] & ~stage_flush[i-1];

      if (enable && !stage_en[IF_STG] && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (redir_go && flush_count != '1)
        flush_count <= flush_count + 1'b1;

      case (state)
        RUN, MEM_WAIT: begin
          if (mem_hold) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_W'(MAX_WAIT)) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end else if (enable && state == MEM_WAIT) begin
            // ack arrived: this cycle advanced normally
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: state <= TIMEOUT;
      endcase
    end
  end

endmodule
